// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: up to four producers share two registered register-file write ports.
// Round-robin scan with a starvation override; same-rd pairs are split across cycles.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req_valid,
  input  logic [4*ADDR_W-1:0]   req_rd,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            req_ready,
  output logic [ADDR_W-1:0]     rd1,
  output logic [ADDR_W-1:0]     rd2,
  output logic [DATA_W-1:0]     wb_data1,
  output logic [DATA_W-1:0]     wb_data2,
  output logic [3:0]            wb_we1,
  output logic [3:0]            wb_we2,
  output logic [1:0]            rr_ptr
);

  // Handshake: a source transfers when req_valid[i] && req_ready[i] at a rising edge;
  // it holds valid/rd/data stable until accepted, and ready is a combinational
  // function of this cycle's valid/rd plus the arbiter state.

  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  wait_cnt_q [4];
  logic [CNT_W-1:0]  wait_cnt_d [4];

  logic [ADDR_W-1:0] rd1_q, rd2_q;
  logic [DATA_W-1:0] wb_data1_q, wb_data2_q;
  logic [3:0]        wb_we1_q, wb_we2_q;

  logic              has_starve;
  logic [1:0]        starve_idx;
  logic [1:0]        scan_idx [5];
  logic              scan_en  [5];

  logic [3:0]        grant;
  logic              p1_used, p2_used, any_port;
  logic [ADDR_W-1:0] p1_rd, p2_rd, rd_v;
  logic [DATA_W-1:0] p1_data, p2_data;
  logic [1:0]        last_idx, idx;

  // Slot 0 holds the starved source (if any); slots 1..4 are the rotation minus that source.
  always_comb begin
    has_starve = 1'b0;
    starve_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[i] && (wait_cnt_q[i] == LIMIT)) begin
        has_starve = 1'b1;
        starve_idx = 2'(i);
      end
    end
    scan_idx[0] = starve_idx;
    scan_en[0]  = has_starve;
    for (int k = 0; k < 4; k++) begin
      scan_idx[k+1] = rr_ptr_q + 2'(k);
      scan_en[k+1]  = !(has_starve && (scan_idx[k+1] == starve_idx));
    end
  end

  always_comb begin
    grant    = 4'b0000;
    p1_used  = 1'b0;
    p2_used  = 1'b0;
    any_port = 1'b0;
    p1_rd    = '0;
    p2_rd    = '0;
    p1_data  = '0;
    p2_data  = '0;
    last_idx = rr_ptr_q;
    idx      = 2'd0;
    rd_v     = '0;
    for (int s = 0; s < 5; s++) begin
      idx  = scan_idx[s];
      rd_v = req_rd[idx*ADDR_W +: ADDR_W];
      if (scan_en[s] && req_valid[idx] && !grant[idx]) begin
        if (rd_v == '0) begin
          grant[idx] = 1'b1;
        end else if (!p1_used) begin
          grant[idx] = 1'b1;
          p1_used    = 1'b1;
          p1_rd      = rd_v;
          p1_data    = req_data[idx*DATA_W +: DATA_W];
          last_idx   = idx;
          any_port   = 1'b1;
        end else if (!p2_used && (rd_v != p1_rd)) begin
          grant[idx] = 1'b1;
          p2_used    = 1'b1;
          p2_rd      = rd_v;
          p2_data    = req_data[idx*DATA_W +: DATA_W];
          last_idx   = idx;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = any_port ? (last_idx + 2'd1) : rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      wait_cnt_d[i] = '0;
      if (req_valid[i] && !grant[i]) begin
        wait_cnt_d[i] = (wait_cnt_q[i] == LIMIT) ? LIMIT : (wait_cnt_q[i] + CNT_ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= 2'd0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      wb_data1_q <= '0;
      wb_data2_q <= '0;
      wb_we1_q   <= 4'd0;
      wb_we2_q   <= 4'd0;
      for (int i = 0; i < 4; i++) wait_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < 4; i++) wait_cnt_q[i] <= wait_cnt_d[i];
      wb_we1_q <= p1_used ? 4'd2 : 4'd0;
      wb_we2_q <= p2_used ? 4'd2 : 4'd0;
      if (p1_used) begin
        rd1_q      <= p1_rd;
        wb_data1_q <= p1_data;
      end
      if (p2_used) begin
        rd2_q      <= p2_rd;
        wb_data2_q <= p2_data;
      end
    end
  end

  // Ready is forced low while reset is held so nothing is accepted into a clearing pipeline.
  assign req_ready = rst_n ? grant : 4'b0000;
  assign rd1       = rd1_q;
  assign rd2       = rd2_q;
  assign wb_data1  = wb_data1_q;
  assign wb_data2  = wb_data2_q;
  assign wb_we1    = wb_we1_q;
  assign wb_we2    = wb_we2_q;
  assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected port writes are queued at stimulus time
// and popped by an independent monitor whenever a write port is enabled.
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LIMIT  = 2;

  logic                clk;
  logic                rst_n;
  logic [3:0]          req_valid;
  logic [4*ADDR_W-1:0] req_rd;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_ready;
  logic [ADDR_W-1:0]   rd1, rd2;
  logic [DATA_W-1:0]   wb_data1, wb_data2;
  logic [3:0]          wb_we1, wb_we2;
  logic [1:0]          rr_ptr;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+DATA_W-1:0] exp1_q [$];
  logic [ADDR_W+DATA_W-1:0] exp2_q [$];

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .rd1(rd1), .rd2(rd2), .wb_data1(wb_data1), .wb_data2(wb_data2),
    .wb_we1(wb_we1), .wb_we2(wb_we2), .rr_ptr(rr_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4*ADDR_W-1:0] pack_rd(input int a0, input int a1, input int a2, input int a3);
    return {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
  endfunction

  function automatic logic [4*DATA_W-1:0] pack_d(input logic [31:0] d0, input logic [31:0] d1,
                                                 input logic [31:0] d2, input logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic push1(input int r, input logic [DATA_W-1:0] d);
    exp1_q.push_back({ADDR_W'(r), d});
  endtask

  task automatic push2(input int r, input logic [DATA_W-1:0] d);
    exp2_q.push_back({ADDR_W'(r), d});
  endtask

  // One cycle of stimulus: checks ready and the pointer the cycle starts with.
  task automatic drive(input logic [3:0] v, input logic [4*ADDR_W-1:0] rd,
                       input logic [4*DATA_W-1:0] d, input logic [3:0] exp_rdy,
                       input logic [1:0] exp_ptr, input string name);
    @(negedge clk);
    req_valid = v;
    req_rd    = rd;
    req_data  = d;
    #1;
    check({name, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    check({name, "_ptr"},   64'(rr_ptr),    64'(exp_ptr));
    @(posedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (wb_we1 !== 4'd0) begin
      if (wb_we1 !== 4'd2 || exp1_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL port1_write: got we=%0h rd=%0h data=%0h, no write expected", wb_we1, rd1, wb_data1);
      end else begin
        check("port1_write", 64'({rd1, wb_data1}), 64'(exp1_q.pop_front()));
      end
    end
    if (wb_we2 !== 4'd0) begin
      if (wb_we2 !== 4'd2 || exp2_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL port2_write: got we=%0h rd=%0h data=%0h, no write expected", wb_we2, rd2, wb_data2);
      end else begin
        check("port2_write", 64'({rd2, wb_data2}), 64'(exp2_q.pop_front()));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    req_rd    = pack_rd(1, 2, 3, 4);
    req_data  = '0;
    #1 rst_n = 1'b0;
    #3;
    check("reset_ready", 64'(req_ready), 64'd0);
    check("reset_we",    64'({wb_we1, wb_we2}), 64'd0);
    check("reset_rd",    64'({rd1, rd2}), 64'd0);
    check("reset_data",  64'({wb_data1, wb_data2}), 64'd0);
    check("reset_ptr",   64'(rr_ptr), 64'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // single ALU0 write
    push1(5, 32'hDEADBEEF);
    drive(4'b0001, pack_rd(5, 0, 0, 0), pack_d(32'hDEADBEEF, 0, 0, 0), 4'b0001, 2'd0, "single");
    drive(4'b0000, '0, '0, 4'b0000, 2'd1, "single_idle");

    // all four valid, distinct rd
    do_reset();
    push1(1, 32'h100); push2(2, 32'h101);
    drive(4'b1111, pack_rd(1, 2, 3, 4), pack_d(32'h100, 32'h101, 32'h102, 32'h103), 4'b0011, 2'd0, "all4_c1");
    push1(3, 32'h102); push2(4, 32'h103);
    drive(4'b1100, pack_rd(0, 0, 3, 4), pack_d(0, 0, 32'h102, 32'h103), 4'b1100, 2'd2, "all4_c2");
    drive(4'b0000, '0, '0, 4'b0000, 2'd0, "all4_idle");

    // same-rd conflict: ALU0 and LSU both to x7
    do_reset();
    push1(7, 32'h11);
    drive(4'b0101, pack_rd(7, 0, 7, 0), pack_d(32'h11, 0, 32'h22, 0), 4'b0001, 2'd0, "samerd_c1");
    push1(7, 32'h22);
    drive(4'b0100, pack_rd(0, 0, 7, 0), pack_d(0, 0, 32'h22, 0), 4'b0100, 2'd1, "samerd_c2");
    drive(4'b0000, '0, '0, 4'b0000, 2'd3, "samerd_idle");

    // x0 drop alongside two real writes
    do_reset();
    push1(8, 32'h44); push2(9, 32'h55);
    drive(4'b1011, pack_rd(8, 9, 0, 0), pack_d(32'h44, 32'h55, 0, 32'h33), 4'b1011, 2'd0, "x0_c1");
    drive(4'b0000, '0, '0, 4'b0000, 2'd2, "x0_idle");

    // starvation override: three sources on x5 keep colliding on port 1
    do_reset();
    push1(5, 32'hA0); push2(6, 32'hD0);
    drive(4'b1111, pack_rd(5, 5, 5, 6), pack_d(32'hA0, 32'hB0, 32'hC0, 32'hD0), 4'b1001, 2'd0, "starve_c1");
    push1(5, 32'hA1); push2(6, 32'hD1);
    drive(4'b1111, pack_rd(5, 5, 5, 6), pack_d(32'hA1, 32'hB0, 32'hC0, 32'hD1), 4'b1001, 2'd0, "starve_c2");
    push1(5, 32'hB0); push2(6, 32'hD2);
    drive(4'b1111, pack_rd(5, 5, 5, 6), pack_d(32'hA2, 32'hB0, 32'hC0, 32'hD2), 4'b1010, 2'd0, "starve_c3");
    push1(5, 32'hC0); push2(6, 32'hD3);
    drive(4'b1101, pack_rd(5, 0, 5, 6), pack_d(32'hA2, 0, 32'hC0, 32'hD3), 4'b1100, 2'd0, "starve_c4");
    push1(5, 32'hA2);
    drive(4'b0001, pack_rd(5, 0, 0, 0), pack_d(32'hA2, 0, 0, 0), 4'b0001, 2'd0, "starve_c5");
    drive(4'b0000, '0, '0, 4'b0000, 2'd1, "starve_idle");

    // reset asserted while a write is on port 1
    do_reset();
    push1(5, 32'h77);
    drive(4'b0001, pack_rd(5, 0, 0, 0), pack_d(32'h77, 0, 0, 0), 4'b0001, 2'd0, "midrst_pre");
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we1",   64'(wb_we1), 64'd0);
    check("midrst_rd1",   64'(rd1), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    push1(1, 32'h200); push2(2, 32'h201);
    drive(4'b1111, pack_rd(1, 2, 3, 4), pack_d(32'h200, 32'h201, 32'h202, 32'h203), 4'b0011, 2'd0, "midrst_post");
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);

    check("q1_drained", 64'(exp1_q.size()), 64'd0);
    check("q2_drained", 64'(exp2_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Writeback arbiter that shares the register file's two write ports among four result producers (ALU0, ALU1, LSU, MUL). Each cycle it selects up to two pending writebacks with valid/ready handshakes and places them on registered write-port outputs that connect directly to the register file's `rd1`/`wb_data1`/`wb_we1` and `rd2`/`wb_data2`/`wb_we2` inputs. Selection is round-robin with a starvation override. Two writes to the same destination are never issued in the same cycle, so no writeback is silently dropped.

## Interface
- `DATA_W`, 32, writeback data width.
- `ADDR_W`, 5, register index width.
- `STARVE_LIMIT`, 7, consecutive stalled cycles before a source is forced to the top priority (≥1).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 4: per-source writeback request. Index 0=ALU0, 1=ALU1, 2=LSU, 3=MUL.
- `req_rd` input 4×`ADDR_W`: per-source destination register, packed with source i at `[i*ADDR_W +: ADDR_W]`.
- `req_data` input 4×`DATA_W`: per-source result data, packed the same way.
- `req_ready` output 4: per-source accept, combinational.
- `rd1`, `rd2` output `ADDR_W`: write-port destinations.
- `wb_data1`, `wb_data2` output `DATA_W`: write-port data.
- `wb_we1`, `wb_we2` output 4: port enable. Value is 4'd2 when writing and 4'd0 when idle.
- `rr_ptr` output 2: current round-robin start index, for debug.

## Operation
- Handshake:
  - A request transfers when `req_valid[i]` and `req_ready[i]` are both high at a rising edge.
  - A source holds `req_valid`, `req_rd` and `req_data` stable until it is accepted.
  - `req_ready` may depend combinationally on `req_valid`/`req_rd` of the same cycle.
- Scan order:
  - Default order is `rr_ptr`, `rr_ptr+1`, … mod 4.
  - Starvation override: if any valid source has `wait_cnt == STARVE_LIMIT`, the lowest-index such source is scanned first. The remaining sources are then scanned in the default order, skipping that source.
- Grant rules, applied in scan order:
  - A valid request with `req_rd == 0` is granted immediately. It consumes no port and produces no write.
  - A valid request with `req_rd != 0` is granted if a port is free. If port 1 already holds a grant this cycle, the request must also satisfy `req_rd != rd` of that port-1 grant.
  - The first port-consuming grant goes to port 1 and the second to port 2. Port 2 is never used while port 1 is empty.
  - Requests that are not granted see `req_ready = 0`.
- Pointer update:
  - If at least one port-consuming grant occurs, `rr_ptr` becomes (index of the last port-consuming grantee + 1) mod 4.
  - Otherwise `rr_ptr` is unchanged.
- Starvation counters:
  - `wait_cnt[i]` increments, saturating at `STARVE_LIMIT`, on each edge where `req_valid[i]` is high and `req_ready[i]` is low.
  - `wait_cnt[i]` clears on acceptance or whenever `req_valid[i]` is low.
- Same-rd conflict: a deferred same-rd request stays pending and issues in a later cycle, after the first write. Final register contents therefore reflect grant order.

## Timing
- Reset (`rst_n` low, asynchronous, effective immediately):
  - `rd1`, `rd2`, `wb_data1`, `wb_data2` = 0.
  - `wb_we1`, `wb_we2` = 4'd0.
  - `rr_ptr` = 0 and all `wait_cnt` = 0.
  - `req_ready` = 4'b0000 while reset is asserted.
- Latency: a request accepted at edge N appears on the port outputs from edge N until edge N+1. The register file commits it at edge N+1.
- Port outputs are registered. In a cycle with no grant for a port, that port's `wb_we` returns to 4'd0; `rd` and data may keep their old values.
- Throughput: at most 2 port writes per cycle, and any number of `rd==0` drops.
- Bound: a continuously valid source is accepted within `STARVE_LIMIT`+4 cycles.
- Reset mid-operation: an in-flight registered write is discarded and outputs clear at once. Sources must re-present their requests after reset releases.

## Test plan
- Single ALU0 request (`rd`=5, data=0xDEADBEEF) → `req_ready[0]`=1 the same cycle. Next cycle `rd1`=5, `wb_data1`=0xDEADBEEF, `wb_we1`=2, `wb_we2`=0.
- All four valid with `rd`=1,2,3,4 and `rr_ptr`=0 → cycle 1 grants sources 0 and 1 and `rr_ptr` becomes 2. Cycle 2 grants sources 2 and 3. Ports show (1,2) then (3,4).
- ALU0 and LSU both `rd`=7 with data 0x11 and 0x22, `rr_ptr`=0 → only ALU0 is granted in cycle 1 and LSU in cycle 2. Port 1 carries 0x11 then 0x22, and `wb_we2` stays 0.
- MUL with `rd`=0 plus ALU0 and ALU1 valid (nonzero `rd`) → all three are ready in one cycle. Two port writes are issued and no write goes to x0.
- ALU0 and ALU1 held valid continuously with LSU valid, `STARVE_LIMIT`=2 → LSU is accepted no later than its third stalled cycle via the override.
- Assert `rst_n` low while `wb_we1`=2 → `wb_we1`=0 and `req_ready`=0 immediately. After release, `rr_ptr`=0 and the first grant follows the default order.
